// File: rtl/adma_atx_ostd_ctrl.sv
// Outstanding-transaction gate between the channel scheduler and the AXI address issuer:
// global/per-channel limits, completion tracking, halt/drain. Optional macro ADMA_OSTD_ERR_EN adds chn_err.
module adma_atx_ostd_ctrl #(
    parameter  int DMA_CHN_NUM   = 4,
    parameter  int ATX_NUM_OSTD  = 4,
    parameter  int CHN_NUM_OSTD  = 2,
    localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
    localparam int OSTD_CNT_W    = $clog2(ATX_NUM_OSTD + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DMA_CHN_NUM_W-1:0] s_atx_chn_id,
    input  logic                     s_atx_vld,
    output logic                     s_atx_rdy,
    output logic [DMA_CHN_NUM_W-1:0] m_atx_chn_id,
    output logic                     m_atx_vld,
    input  logic                     m_atx_rdy,
    input  logic [DMA_CHN_NUM_W-1:0] cmpl_chn_id,
    input  logic                     cmpl_err,
    input  logic                     cmpl_vld,
    output logic [DMA_CHN_NUM-1:0]   atx_done,
    output logic [DMA_CHN_NUM-1:0]   chn_idle,
    output logic [OSTD_CNT_W-1:0]    ostd_cnt,
    input  logic                     halt_req,
    output logic                     halt_ack,
    output logic                     proto_err
`ifdef ADMA_OSTD_ERR_EN
    ,
    output logic [DMA_CHN_NUM-1:0]   chn_err
`endif
);
    localparam logic [OSTD_CNT_W-1:0] ONE     = OSTD_CNT_W'(1);
    localparam logic [OSTD_CNT_W-1:0] ATX_MAX = OSTD_CNT_W'(ATX_NUM_OSTD);
    localparam logic [OSTD_CNT_W-1:0] CHN_MAX = OSTD_CNT_W'(CHN_NUM_OSTD);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t                 state;
    logic [OSTD_CNT_W-1:0]  chn_cnt     [DMA_CHN_NUM];
    logic [OSTD_CNT_W-1:0]  chn_cnt_nxt [DMA_CHN_NUM];
    logic [OSTD_CNT_W-1:0]  ostd_nxt;
    logic [DMA_CHN_NUM-1:0] s_sel, c_sel, err_blk;
    logic                   s_room, c_busy, gate, issue, cmpl_ok;

    // One-hot decode of both ids; an out-of-range id selects nothing, so its completion is invalid.
    always_comb begin
        s_sel  = '0;
        c_sel  = '0;
        s_room = 1'b0;
        c_busy = 1'b0;
        for (int i = 0; i < DMA_CHN_NUM; i++) begin
            s_sel[i] = (s_atx_chn_id == DMA_CHN_NUM_W'(i));
            c_sel[i] = (cmpl_chn_id == DMA_CHN_NUM_W'(i));
            if (s_sel[i]) s_room = (chn_cnt[i] < CHN_MAX) && !err_blk[i];
            if (c_sel[i]) c_busy = (chn_cnt[i] != '0);
        end
    end

    assign gate         = (state == RUN) && (ostd_cnt < ATX_MAX) && s_room;
    assign m_atx_vld    = s_atx_vld && gate;
    assign s_atx_rdy    = m_atx_rdy && gate;
    assign m_atx_chn_id = s_atx_chn_id;
    assign issue        = s_atx_vld && s_atx_rdy;
    assign cmpl_ok      = cmpl_vld && c_busy;

    // An issue and a completion on the same counter in one cycle cancel out.
    always_comb begin
        ostd_nxt = ostd_cnt;
        if (issue && !cmpl_ok)
            ostd_nxt = ostd_cnt + ONE;
        else if (!issue && cmpl_ok)
            ostd_nxt = ostd_cnt - ONE;
        for (int i = 0; i < DMA_CHN_NUM; i++) begin
            chn_cnt_nxt[i] = chn_cnt[i];
            if (issue && s_sel[i] && !(cmpl_ok && c_sel[i]))
                chn_cnt_nxt[i] = chn_cnt[i] + ONE;
            else if (cmpl_ok && c_sel[i] && !(issue && s_sel[i]))
                chn_cnt_nxt[i] = chn_cnt[i] - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            halt_ack  <= 1'b0;
            ostd_cnt  <= '0;
            atx_done  <= '0;
            chn_idle  <= '1;
            proto_err <= 1'b0;
            for (int i = 0; i < DMA_CHN_NUM; i++) chn_cnt[i] <= '0;
        end else begin
            ostd_cnt <= ostd_nxt;
            atx_done <= c_sel & {DMA_CHN_NUM{cmpl_ok}};
            if (cmpl_vld && !c_busy) proto_err <= 1'b1;
            for (int i = 0; i < DMA_CHN_NUM; i++) begin
                chn_cnt[i]  <= chn_cnt_nxt[i];
                chn_idle[i] <= (chn_cnt_nxt[i] == '0);
            end
            // Dropping halt_req always wins, even mid-drain.
            case (state)
                RUN: begin
                    if (halt_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!halt_req) begin
                        state <= RUN;
                    end else if (ostd_cnt == '0) begin
                        state    <= HALTED;
                        halt_ack <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state    <= RUN;
                        halt_ack <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    halt_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADMA_OSTD_ERR_EN
    // Error sticks until the channel's last outstanding transaction completes cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            chn_err <= '0;
        end else begin
            for (int i = 0; i < DMA_CHN_NUM; i++) begin
                if (cmpl_ok && c_sel[i]) begin
                    if (cmpl_err)
                        chn_err[i] <= 1'b1;
                    else if (chn_cnt[i] == ONE)
                        chn_err[i] <= 1'b0;
                end
            end
        end
    end
    assign err_blk = chn_err;
`else
    logic unused_cmpl_err;
    assign unused_cmpl_err = cmpl_err;
    assign err_blk = '0;
`endif

endmodule
